// File: rtl/ov7670_dvp_source.sv
`default_nettype none
// ============================================================================
// Module      : ov7670_dvp_source
// Description : Emulates the DVP output of an OV7670 camera running RGB565.
//               Generates pclk (clk24/2), vsync, href and an 8-bit data byte
//               carrying one of four synthetic test patterns, with full frame
//               timing (VSYNC, back porch, active lines, front porch).
// Ports       : clk24     - sole clock, rising edge
//               rst_n     - asynchronous active-low reset
//               en        - run request, sampled at frame boundaries
//               mode      - pattern: 0 ramp, 1 bars, 2 checker, 3 solid
//               pclk      - emulated pixel clock (registered)
//               vsync     - high for the VSYNC line periods
//               href      - high during active bytes
//               d         - data byte, 0x00 whenever href is low
//               busy      - high whenever a frame is in progress
//               frame_end - one-cycle pulse on the last clk24 of a frame
//               frame_cnt - completed-frame counter, wraps 255 -> 0
// Revision    : 1.0 - initial release
// ============================================================================
module ov7670_dvp_source #(
  parameter int WIDTH       = 640,
  parameter int HEIGHT      = 480,
  parameter int HBLANK      = 144,
  parameter int VSYNC_LINES = 3,
  parameter int VBP_LINES   = 17,
  parameter int VFP_LINES   = 10
) (
  input  logic       clk24,
  input  logic       rst_n,
  input  logic       en,
  input  logic [1:0] mode,
  output logic       pclk,
  output logic       vsync,
  output logic       href,
  output logic [7:0] d,
  output logic       busy,
  output logic       frame_end,
  output logic [7:0] frame_cnt
);

  localparam int c_LINE_BYTES = 2 * WIDTH + HBLANK;
  localparam int c_HW         = (c_LINE_BYTES > 1) ? $clog2(c_LINE_BYTES) : 1;
  localparam int c_LMAX_A     = (VSYNC_LINES > VBP_LINES) ? VSYNC_LINES : VBP_LINES;
  localparam int c_LMAX_B     = (HEIGHT > VFP_LINES) ? HEIGHT : VFP_LINES;
  localparam int c_LMAX       = (c_LMAX_A > c_LMAX_B) ? c_LMAX_A : c_LMAX_B;
  localparam int c_LW         = (c_LMAX > 1) ? $clog2(c_LMAX) : 1;

  localparam logic [c_HW-1:0] c_HLAST  = c_HW'(c_LINE_BYTES - 1);
  localparam logic [15:0]     c_BAR_W  = 16'((WIDTH >= 8) ? (WIDTH / 8) : 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_VSYNC  = 3'd1,
    S_VBP    = 3'd2,
    S_ACTIVE = 3'd3,
    S_VFP    = 3'd4
  } state_t;

  state_t          r_state, w_state_nxt;
  logic [c_HW-1:0] r_hcnt, w_hcnt_nxt;
  logic [c_LW-1:0] r_line, w_line_nxt, w_line_last;
  logic [1:0]      r_mode_q, w_mode_nxt;
  logic            w_eol;
  logic            w_eos;

  logic [15:0]     w_x16;
  logic [7:0]      w_y8;
  logic [15:0]     w_bar;
  logic [2:0]      w_bar_idx;
  logic [15:0]     w_pixel;
  logic            w_href_nxt;
  logic [7:0]      w_byte;

  // Position of the byte that begins on the next phase-0 cycle. Only
  // consumed on the edge entering phase 0, so the position advances once
  // per byte period.
  always_comb begin
    w_state_nxt = r_state;
    w_hcnt_nxt  = r_hcnt;
    w_line_nxt  = r_line;
    w_mode_nxt  = r_mode_q;

    case (r_state)
      S_VSYNC:  w_line_last = c_LW'(VSYNC_LINES - 1);
      S_VBP:    w_line_last = c_LW'(VBP_LINES - 1);
      S_ACTIVE: w_line_last = c_LW'(HEIGHT - 1);
      S_VFP:    w_line_last = c_LW'(VFP_LINES - 1);
      default:  w_line_last = '0;
    endcase

    w_eol = (r_hcnt == c_HLAST);
    w_eos = w_eol && (r_line == w_line_last);

    if (r_state == S_IDLE) begin
      if (en) begin
        w_state_nxt = S_VSYNC;
        w_hcnt_nxt  = '0;
        w_line_nxt  = '0;
        w_mode_nxt  = mode;
      end
    end else if (w_eol) begin
      w_hcnt_nxt = '0;
      if (r_line == w_line_last) begin
        w_line_nxt = '0;
        case (r_state)
          S_VSYNC:  w_state_nxt = S_VBP;
          S_VBP:    w_state_nxt = S_ACTIVE;
          S_ACTIVE: w_state_nxt = S_VFP;
          S_VFP: begin
            // Frame boundary: en decides whether another frame follows,
            // and the pattern for that frame is captured here.
            if (en) begin
              w_state_nxt = S_VSYNC;
              w_mode_nxt  = mode;
            end else begin
              w_state_nxt = S_IDLE;
            end
          end
          default:  w_state_nxt = S_IDLE;
        endcase
      end else begin
        w_line_nxt = r_line + 1'b1;
      end
    end else begin
      w_hcnt_nxt = r_hcnt + 1'b1;
    end
  end

  // Pattern generator for the next byte position.
  always_comb begin
    w_x16     = 16'(w_hcnt_nxt >> 1);
    w_y8      = 8'(w_line_nxt);
    w_bar     = w_x16 / c_BAR_W;
    w_bar_idx = (w_bar > 16'd7) ? 3'd7 : w_bar[2:0];

    case (w_mode_nxt)
      2'd0: w_pixel = {w_y8, w_x16[7:0]};
      2'd1: begin
        case (w_bar_idx)
          3'd0:    w_pixel = 16'hFFFF;
          3'd1:    w_pixel = 16'hFFE0;
          3'd2:    w_pixel = 16'h07FF;
          3'd3:    w_pixel = 16'h07E0;
          3'd4:    w_pixel = 16'hF81F;
          3'd5:    w_pixel = 16'hF800;
          3'd6:    w_pixel = 16'h001F;
          default: w_pixel = 16'h0000;
        endcase
      end
      2'd2:    w_pixel = (w_x16[3] ^ w_y8[3]) ? 16'hFFFF : 16'h0000;
      default: w_pixel = {frame_cnt, frame_cnt};
    endcase

    w_href_nxt = (w_state_nxt == S_ACTIVE) && (int'(w_hcnt_nxt) < 2 * WIDTH);
    w_byte     = w_hcnt_nxt[0] ? w_pixel[7:0] : w_pixel[15:8];
  end

  // pclk doubles as the phase bit: pclk=1 now means the next cycle is
  // phase 0, where position and outputs update.
  always_ff @(posedge clk24 or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_hcnt    <= '0;
      r_line    <= '0;
      r_mode_q  <= 2'd0;
      pclk      <= 1'b0;
      vsync     <= 1'b0;
      href      <= 1'b0;
      d         <= 8'h00;
      busy      <= 1'b0;
      frame_end <= 1'b0;
      frame_cnt <= 8'h00;
    end else begin
      pclk      <= ~pclk;
      frame_end <= 1'b0;
      if (pclk) begin
        r_state  <= w_state_nxt;
        r_hcnt   <= w_hcnt_nxt;
        r_line   <= w_line_nxt;
        r_mode_q <= w_mode_nxt;
        vsync    <= (w_state_nxt == S_VSYNC);
        href     <= w_href_nxt;
        d        <= w_href_nxt ? w_byte : 8'h00;
        busy     <= (w_state_nxt != S_IDLE);
      end else if ((r_state == S_VFP) && w_eos) begin
        // Entering phase 1 of the final VFP byte.
        frame_end <= 1'b1;
        frame_cnt <= frame_cnt + 8'd1;
      end
    end
  end

endmodule
`default_nettype wire
